snake_dir_input: RTL

Button-conditioning and direction-arbitration stage that sits directly upstream of the snake game-state logic in the top level. It synchronises and debounces the four raw direction push-buttons and converts presses into direction requests. It rejects illegal 180° reversals and holds the latest legal request until the game engine's step strobe commits it. The committed direction drives the engine's `move1` input, using the existing move encoding: 1=up, 2=right, 3=down, 4=left, 5=none.

---
 rtl/snake_dir_input.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/snake_dir_input.sv
// Conditions the four direction buttons and arbitrates them into a committed move
// direction (1=up, 2=right, 3=down, 4=left, 5=none) that updates on the game tick.
module snake_dir_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  input  logic       tick,
  output logic [2:0] dir_out,
  output logic       pending_valid,
  output logic [2:0] pending_dir,
  output logic       dir_changed
);

  typedef enum logic [2:0] {
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_LEFT  = 3'd4,
    DIR_NONE  = 3'd5
  } dir_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic dir_e opposite(input dir_e d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_RIGHT: return DIR_LEFT;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return DIR_NONE;
    endcase
  endfunction

  // Bit order: 0=up, 1=right, 2=down, 3=left (also the press priority order).
  logic [3:0]       btn_raw;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       deb_q, deb_d;
  logic [3:0]       deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  dir_e dir_q, dir_d;
  dir_e pend_dir_q, pend_dir_d;
  logic pend_valid_q, pend_valid_d;
  logic changed_q, changed_d;

  logic [3:0] press;
  logic       req_valid;
  dir_e       req_dir;
  dir_e       ref_dir;
  logic       req_legal;
  logic       commit;

  assign btn_raw = {left, down, right, up};

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_NONE;
    if (press[0])      req_dir = DIR_UP;
    else if (press[1]) req_dir = DIR_RIGHT;
    else if (press[2]) req_dir = DIR_DOWN;
    else if (press[3]) req_dir = DIR_LEFT;
    else               req_valid = 1'b0;
  end

  // Legality is judged against the direction that will be live after this edge,
  // so a request racing a commit is checked against the newly committed value.
  always_comb begin
    commit    = tick & pend_valid_q;
    ref_dir   = commit ? pend_dir_q : dir_q;
    req_legal = req_valid &&
                ((ref_dir == DIR_NONE) ||
                 ((req_dir != ref_dir) && (req_dir != opposite(ref_dir))));
  end

  always_comb begin
    dir_d        = commit ? pend_dir_q : dir_q;
    changed_d    = commit;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    if (req_legal) begin
      pend_dir_d   = req_dir;
      pend_valid_d = 1'b1;
    end else if (commit) begin
      pend_dir_d   = DIR_NONE;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      dir_q        <= DIR_NONE;
      pend_dir_q   <= DIR_NONE;
      pend_valid_q <= 1'b0;
      changed_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      changed_q    <= changed_d;
    end
  end

  assign dir_out       = dir_q;
  assign pending_dir   = pend_dir_q;
  assign pending_valid = pend_valid_q;
  assign dir_changed   = changed_q;

endmodule
